// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared FSM state type and register-index constants for the read arbiter
package regfile_arb_pkg;
   typedef enum logic [1:0] {IDLE, RESP, STALL} arb_state_t;
   localparam int REG_ADDR_W = 5;
   localparam int XZR_IDX = 31;
endpackage

// File: rtl/regfile_read_arb_rr_pick.sv
// rr_pick: combinational round-robin one-hot picker, first valid at or above i_ptr modulo N
module rr_pick #(
   parameter int N = 4,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  i_valid,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx
);
   logic          w_found;
   logic [PW:0]   w_j;
   // scan N positions starting at the pointer, wrapping at N; the first valid one wins
   always_comb begin
      o_grant = '0;
      o_idx = '0;
      w_found = 1'b0;
      w_j = '0;
      for (int k = 0; k < N; k++) begin
         w_j = {1'b0, i_ptr} + (PW+1)'(k);
         w_j = (w_j >= (PW+1)'(N)) ? w_j - (PW+1)'(N) : w_j;
         if (!w_found && i_valid[w_j[PW-1:0]]) begin
            w_found = 1'b1;
            o_grant[w_j[PW-1:0]] = 1'b1;
            o_idx = w_j[PW-1:0];
         end
      end
   end
endmodule

// File: rtl/regfile_read_arb.sv
// regfile_read_arb: round-robin arbiter sharing one register-file read port; REGFILE_ARB_XZR_EN makes index 31 read as zero
module regfile_read_arb
   import regfile_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DATA_W = 64,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
   output logic [NREQ-1:0]            req_ready,
   output logic [REG_ADDR_W-1:0]      rf_sel,
   input  logic [DATA_W-1:0]          rf_data,
   output logic                       resp_valid,
   output logic [IDW-1:0]             resp_id,
   output logic [DATA_W-1:0]          resp_data,
   input  logic                       resp_ready
);
   arb_state_t          r_state;
   logic [IDW-1:0]      r_ptr;
   logic [IDW-1:0]      r_resp_id;
   logic [DATA_W-1:0]   r_resp_data;
   logic [NREQ-1:0]     w_grant;
   logic [IDW-1:0]      w_idx;
   logic [IDW-1:0]      w_ptr_next;
   logic                w_free;
   logic                w_accept;
   logic [DATA_W-1:0]   w_data;

   rr_pick #(.N(NREQ)) u_pick (
      .i_valid(req_valid),
      .i_ptr(r_ptr),
      .o_grant(w_grant),
      .o_idx(w_idx)
   );

   assign resp_valid = (r_state != IDLE);
   assign resp_id = r_resp_id;
   assign resp_data = r_resp_data;
   assign w_free = !resp_valid || resp_ready;
   assign req_ready = (w_free && !reset) ? w_grant : '0;
   assign w_accept = |req_ready;
   assign rf_sel = w_accept ? req_addr[w_idx*REG_ADDR_W +: REG_ADDR_W] : '0;
   assign w_ptr_next = (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
`ifdef REGFILE_ARB_XZR_EN
   assign w_data = (rf_sel == REG_ADDR_W'(XZR_IDX)) ? '0 : rf_data;
`else
   assign w_data = rf_data;
`endif

   // response FSM: capture on accept, drop to IDLE on drain, sit in STALL while the consumer holds off
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr <= '0;
         r_resp_id <= '0;
         r_resp_data <= '0;
      end else if (w_accept) begin
         r_state <= RESP;
         r_ptr <= w_ptr_next;
         r_resp_id <= w_idx;
         r_resp_data <= w_data;
      end else if (r_state != IDLE) begin
         r_state <= resp_ready ? IDLE : STALL;
      end
   end
endmodule

// File: tb/tb_regfile_read_arb.sv
// tb_regfile_read_arb: scoreboard bench with a behavioural round-robin model and a register-file stand-in
module tb_regfile_read_arb;
   localparam int NREQ = 4;
   localparam int DW = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*5-1:0] req_addr = '0;
   logic [NREQ-1:0]   req_ready;
   logic [4:0]        rf_sel;
   logic [DW-1:0]     rf_data;
   logic              resp_valid;
   logic [1:0]        resp_id;
   logic [DW-1:0]     resp_data;
   logic              resp_ready = 1'b1;

   logic [DW-1:0] regs [32];
   typedef struct {int id; logic [DW-1:0] data;} exp_t;
   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int m_ptr = 0;
   bit m_valid = 0;

   regfile_read_arb #(.NREQ(NREQ), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .rf_sel(rf_sel), .rf_data(rf_data),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
      .resp_ready(resp_ready)
   );

   always #5 clk = ~clk;
   assign rf_data = regs[rf_sel];

   task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*5-1:0] a, input logic rr, input logic rst);
      int g;
      logic [4:0] ad;
      logic [DW-1:0] d;
      exp_t e;
      @(negedge clk);
      req_valid = v;
      req_addr = a;
      resp_ready = rr;
      reset = rst;
      #1;
      g = -1;
      if (!rst && (!m_valid || rr))
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      ad = (g >= 0) ? a[g*5 +: 5] : 5'd0;
      chk("req_ready", DW'(req_ready), (g >= 0) ? DW'(1) << g : '0);
      chk("rf_sel", DW'(rf_sel), DW'(ad));
      if (!rst) chk("resp_valid", DW'(resp_valid), DW'(m_valid));
      if (rst) begin
         m_valid = 0;
         m_ptr = 0;
         q.delete();
      end else if (g >= 0) begin
         d = regs[ad];
`ifdef REGFILE_ARB_XZR_EN
         if (ad == 5'd31) d = '0;
`endif
         e.id = g;
         e.data = d;
         q.push_back(e);
         m_valid = 1;
         m_ptr = (g + 1) % NREQ;
      end else if (m_valid && rr) begin
         m_valid = 0;
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL resp_unexpected: got id %0d with no response expected", resp_id);
            end else begin
               e = q.pop_front();
               chk("resp_id", DW'(resp_id), DW'(e.id));
               chk("resp_data", resp_data, e.data);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
      regs[5] = 64'hA5;
      regs[31] = 64'hFFFF;
      cycle('0, '0, 1'b1, 1'b1);
      cycle('0, '0, 1'b1, 1'b1);
      cycle('0, '0, 1'b1, 1'b0);
      cycle(4'b0001, 20'd5, 1'b1, 1'b0);
      cycle('0, '0, 1'b1, 1'b0);
      cycle('0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) cycle(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(4'b1111, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b0, 1'b0);
      cycle(4'b1111, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b1, 1'b0);
      cycle(4'b0100, {5'd0, 5'd31, 5'd0, 5'd0}, 1'b1, 1'b0);
      cycle('0, '0, 1'b1, 1'b0);
      cycle(4'b0010, {5'd0, 5'd0, 5'd31, 5'd0}, 1'b1, 1'b0);
      cycle(4'b1111, {5'd9, 5'd10, 5'd11, 5'd12}, 1'b0, 1'b0);
      cycle(4'b1111, {5'd9, 5'd10, 5'd11, 5'd12}, 1'b0, 1'b0);
      cycle(4'b1111, {5'd9, 5'd10, 5'd11, 5'd12}, 1'b0, 1'b1);
      cycle(4'b1111, {5'd13, 5'd14, 5'd15, 5'd16}, 1'b1, 1'b0);
      cycle('0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3000; i++)
         cycle(NREQ'($urandom), (NREQ*5)'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      for (int i = 0; i < 3; i++) cycle('0, '0, 1'b1, 1'b0);
      chk("queue_drained", DW'(q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
